// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer for a synchronous (1-cycle) memory,
// with a 2-entry output buffer, redirect flush and run/drain control.
`default_nettype none
`timescale 1ns/1ps

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] i_addr,
  input  logic [31:0] instruction,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam logic [31:0] LAST_PC = 32'(4 * MEM_WORDS - 4);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]  count_q, count_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;

  logic [31:0] target_pc;
  logic [31:0] issue_addr;
  logic [31:0] next_pc;
  logic        pop;
  logic        slot_ok;
  logic        issue;
  logic        unused_low_bits;

  assign unused_low_bits = ^redirect_pc[1:0];

  always_comb begin
    target_pc  = {redirect_pc[31:2], 2'b00};
    issue_addr = redirect_valid ? target_pc : fetch_pc_q;
    next_pc    = (issue_addr == LAST_PC) ? 32'h0 : issue_addr + 32'd4;
    pop        = out_valid_q && out_ready;

    // A redirect empties both buffer and in-flight slot, so a slot is always free.
    if (redirect_valid) begin
      slot_ok = 1'b1;
    end else begin
      slot_ok = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    end
    issue = run_en && slot_ok;

    if (run_en) begin
      state_d = RUN;
    end else if (redirect_valid) begin
      state_d = state_q;
    end else begin
      state_d = IDLE;
    end

    fetch_pc_d    = issue ? next_pc : issue_addr;
    inflight_d    = issue;
    inflight_pc_d = issue ? issue_addr : inflight_pc_q;

    count_d      = count_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        out_pc_d    = tail_pc_q;
        out_instr_d = tail_instr_q;
        count_d     = count_d - 2'd1;
      end
      if (inflight_q) begin
        if (count_d == 2'd0) begin
          out_pc_d    = inflight_pc_q;
          out_instr_d = instruction;
        end else begin
          tail_pc_d    = inflight_pc_q;
          tail_instr_d = instruction;
        end
        count_d = count_d + 2'd1;
      end
    end
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= 2'd0;
      out_valid_q   <= 1'b0;
      out_pc_q      <= 32'h0;
      out_instr_q   <= 32'h0;
      tail_pc_q     <= 32'h0;
      tail_instr_q  <= 32'h0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      tail_pc_q     <= tail_pc_d;
      tail_instr_q  <= tail_instr_d;
    end
  end

  assign i_addr    = issue_addr;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard of expected {pc, instr} per transfer, table of
// redirect vectors, and hand sequences for stall, drain and reset corners.
`timescale 1ns/1ps

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] i_addr;
  logic [31:0] instruction = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0000_0000), .MEM_WORDS(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_en         (run_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .i_addr         (i_addr),
    .instruction    (instruction),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  // Memory word k holds 32'h1000_0000 + k, registered on the sampling edge.
  always @(posedge clk) instruction <= 32'h1000_0000 + {2'b00, i_addr[31:2]};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_pc;
  } redir_vec_t;

  redir_vec_t vec[4];

  function automatic logic [31:0] nxt(input logic [31:0] pc);
    return (pc == 32'h0000_0FFC) ? 32'h0 : pc + 32'd4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    logic [31:0] pc;
    exp_q.delete();
    pc = start;
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(pc);
      pc = nxt(pc);
    end
  endtask

  task automatic sample();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got pc %h expected none", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("out_pc", out_pc, e);
        check("out_instr", out_instr, 32'h1000_0000 + (e >> 2));
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      sample();
      adv();
    end
  endtask

  initial begin
    logic [31:0] hold;
    logic [31:0] first;

    vec[0] = '{32'h0000_0103, 32'h0000_0100};
    vec[1] = '{32'h0000_0FFA, 32'h0000_0FF8};
    vec[2] = '{32'h0000_0002, 32'h0000_0000};
    vec[3] = '{32'h0000_07FF, 32'h0000_07FC};

    rst_n = 1'b0; run_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_i_addr", i_addr, 32'h0);
    adv();

    // Reset release with a free-running stream
    push_stream(32'h0, 64);
    rst_n = 1'b1; run_en = 1'b1; out_ready = 1'b1; n_xfer = 0;
    sample(); check("valid_c0", {31'h0, out_valid}, 32'h0); adv();
    sample(); check("valid_c1", {31'h0, out_valid}, 32'h0); adv();
    sample(); check("valid_c2", {31'h0, out_valid}, 32'h1); adv();
    cycles(15);
    check("throughput", 32'(n_xfer), 32'd16);

    // Five-cycle backpressure
    out_ready = 1'b0;
    cycles(2);
    sample(); hold = i_addr; adv();
    cycles(1);
    sample();
    check("i_addr_hold", i_addr, hold);
    check("valid_stall", {31'h0, out_valid}, 32'h1);
    adv();
    out_ready = 1'b1; n_xfer = 0;
    cycles(10);
    check("resume_xfer", 32'(n_xfer), 32'd10);

    // Redirects with a full buffer, table-driven
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      cycles(4);
      redirect_valid = 1'b1; redirect_pc = vec[i].rpc;
      sample();
      check("redir_i_addr", i_addr, vec[i].exp_pc);
      push_stream(vec[i].exp_pc, 32);
      adv();
      redirect_valid = 1'b0; out_ready = 1'b1;
      sample(); check("flush_valid", {31'h0, out_valid}, 32'h0); adv();
      sample(); check("redir_valid", {31'h0, out_valid}, 32'h1); adv();
      cycles(6);
    end

    // Back-to-back redirects: only the second stream may appear
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    sample(); push_stream(32'h0000_0200, 8); adv();
    redirect_pc = 32'h0000_0300;
    sample();
    check("b2b_i_addr", i_addr, 32'h0000_0300);
    push_stream(32'h0000_0300, 32);
    adv();
    redirect_valid = 1'b0;
    sample(); check("b2b_flush", {31'h0, out_valid}, 32'h0); adv();
    cycles(6);

    // Drain, then a single fetch launched just before run_en drops
    run_en = 1'b0;
    cycles(4);
    sample(); check("drained", {31'h0, out_valid}, 32'h0); adv();
    run_en = 1'b1;
    sample(); first = exp_q[0]; check("single_issue_addr", i_addr, first); adv();
    run_en = 1'b0; n_xfer = 0;
    cycles(6);
    check("single_xfer", 32'(n_xfer), 32'd1);
    sample();
    check("single_idle_valid", {31'h0, out_valid}, 32'h0);
    check("single_no_issue", i_addr, nxt(first));
    adv();

    // Asynchronous reset with a full buffer
    run_en = 1'b1; out_ready = 1'b0;
    cycles(5);
    sample(); check("full_valid", {31'h0, out_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst_pc", out_pc, 32'h0);
    adv(); adv();
    push_stream(32'h0, 32);
    rst_n = 1'b1; out_ready = 1'b1; n_xfer = 0;
    cycles(2);
    sample(); check("restart_valid", {31'h0, out_valid}, 32'h1); adv();
    cycles(8);
    check("restart_xfer", 32'(n_xfer), 32'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
